ble_auth_rx: RTL and testbench

Receive side of the BLE command link. Deserializes 8N1 UART frames arriving on `RX` and runs the power-up authorization state machine that drives `pwr_up` to the balance controller. It sits inside `Segway` between the `RX` pin and the balance/steering logic. It is the counterpart of the bench-side `UART_tx` that issues `'g'` (0x67) and `'s'` (0x73).

---
 rtl/ble_pkg.sv | 24 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 rtl/ble_auth_rx.sv | 91 +++++++++
 tb/tb_ble_auth_rx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared types and defaults for the BLE command receive path.
// Holds the receiver and authorization state enums, the baud counter
// width and the default baud divisor and command byte values.
package ble_pkg;

    localparam int          CNT_W        = 12;
    localparam int          BAUD_DIV_DEF = 2604;
    localparam logic [7:0]  CMD_GO_DEF   = 8'h67;
    localparam logic [7:0]  CMD_STOP_DEF = 8'h73;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PWR1 = 2'd1,
        PWR2 = 2'd2
    } auth_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, 12-bit down-counting baud timer,
// LSB-first shift register and receiver FSM.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   RX       in   asynchronous serial line, idle high
//   rx_data  out  last correctly framed byte
//   rx_rdy   out  one-cycle pulse, rx_data valid
//   frm_err  out  one-cycle pulse, stop bit sampled low
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to mid start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high delivers the byte, low flags error
module uart_rx
    import ble_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    // Expiry is the cycle after the counter reaches zero, so a load of L
    // gives L+1 cycles. Reloading BAUD_DIV-1 keeps every bit exactly
    // BAUD_DIV clocks apart.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BAUD_DIV - 1);

    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_rdy;
    logic             r_frm_err;

    logic w_fall;
    logic w_expire;
    logic w_load_half;
    logic w_load_bit;
    logic w_clr_bits;
    logic w_shift_en;
    logic w_frame_ok;
    logic w_frame_bad;

    assign w_fall   = r_rx_prev & ~r_rx_s;
    assign w_expire = (r_cnt == '0);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_nxt = START;
            START:   if (w_expire) w_state_nxt = r_rx_s ? IDLE : DATA;
            DATA:    if (w_expire && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
            STOP:    if (w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // output / datapath control
    always_comb begin
        w_load_half = 1'b0;
        w_load_bit  = 1'b0;
        w_clr_bits  = 1'b0;
        w_shift_en  = 1'b0;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            IDLE:  w_load_half = w_fall;
            START: begin
                if (w_expire && !r_rx_s) begin
                    w_load_bit = 1'b1;
                    w_clr_bits = 1'b1;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_load_bit = 1'b1;
                    w_shift_en = 1'b1;
                end
            end
            STOP: begin
                if (w_expire) begin
                    w_frame_ok  = r_rx_s;
                    w_frame_bad = ~r_rx_s;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rx_rdy  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_rx_rdy  <= w_frame_ok;
            r_frm_err <= w_frame_bad;

            if (w_load_half) begin
                r_cnt <= CNT_HALF;
            end else if (w_load_bit) begin
                r_cnt <= CNT_BIT;
            end else if (!w_expire) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_clr_bits) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end

            if (w_frame_ok) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rx_rdy;
    assign frm_err = r_frm_err;

endmodule

// File: rtl/ble_auth_rx.sv
// BLE command link receive side: UART receiver plus the power-up
// authorization FSM that drives pwr_up to the balance controller.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   RX         in   asynchronous serial line, idle high
//   rider_off  in   high when load cells report no rider
//   rx_data    out  last correctly framed byte
//   rx_rdy     out  one-cycle pulse, rx_data valid
//   frm_err    out  one-cycle pulse, stop bit sampled low
//   pwr_up     out  motors/balance enabled
//
// state | meaning
// OFF   | not authorized, motors disabled
// PWR1  | authorized by CMD_GO, rider_off ignored until CMD_STOP
// PWR2  | stop requested with rider on; powers down once rider_off rises
module ble_auth_rx
    import ble_pkg::*;
#(
    parameter int         BAUD_DIV = BAUD_DIV_DEF,
    parameter logic [7:0] CMD_GO   = CMD_GO_DEF,
    parameter logic [7:0] CMD_STOP = CMD_STOP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    auth_state_t r_auth;
    auth_state_t w_auth_nxt;
    logic        r_pwr_up;
    logic        w_pwr_nxt;
    logic        w_cmd_go;
    logic        w_cmd_stop;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err)
    );

    assign w_cmd_go   = rx_rdy && (rx_data == CMD_GO);
    assign w_cmd_stop = rx_rdy && (rx_data == CMD_STOP);

    // state register; pwr_up is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auth   <= OFF;
            r_pwr_up <= 1'b0;
        end else begin
            r_auth   <= w_auth_nxt;
            r_pwr_up <= w_pwr_nxt;
        end
    end

    // next-state logic; in PWR2 a GO byte takes priority over rider_off
    always_comb begin
        w_auth_nxt = r_auth;
        case (r_auth)
            OFF:  if (w_cmd_go) w_auth_nxt = PWR1;
            PWR1: if (w_cmd_stop) w_auth_nxt = rider_off ? OFF : PWR2;
            PWR2: begin
                if (w_cmd_go) begin
                    w_auth_nxt = PWR1;
                end else if (rider_off) begin
                    w_auth_nxt = OFF;
                end
            end
            default: w_auth_nxt = OFF;
        endcase
    end

    // output logic
    always_comb begin
        w_pwr_nxt = (w_auth_nxt != OFF);
    end

    assign pwr_up = r_pwr_up;

endmodule

// File: tb/tb_ble_auth_rx.sv
module tb_ble_auth_rx;

    localparam int N    = 20;
    localparam int LAT  = 3 + N / 2 + 9 * N;
    localparam int ND   = 2604;
    localparam int LATD = 3 + ND / 2 + 9 * ND;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    logic       rx_d;
    logic       ro_d;
    logic [7:0] rx_data_d;
    logic       rx_rdy_d;
    logic       frm_err_d;
    logic       pwr_up_d;

    always #5 clk = ~clk;

    ble_auth_rx #(.BAUD_DIV(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err),
        .pwr_up    (pwr_up)
    );

    ble_auth_rx dut_def (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx_d),
        .rider_off (ro_d),
        .rx_data   (rx_data_d),
        .rx_rdy    (rx_rdy_d),
        .frm_err   (frm_err_d),
        .pwr_up    (pwr_up_d)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitors, sampled on the falling edge
    int         rdy_n = 0, err_n = 0, rdy_cyc = 0, err_cyc = 0;
    logic       pwr_after = 1'b0;
    bit         cap_next = 1'b0;
    int         rdy_n_d = 0, err_n_d = 0, rdy_cyc_d = 0;
    logic       pwr_at_d = 1'b0, pwr_after_d = 1'b0;
    bit         cap_next_d = 1'b0;

    always @(negedge clk) begin
        if (cap_next) begin
            pwr_after = pwr_up;
            cap_next  = 1'b0;
        end
        if (rx_rdy) begin
            rdy_n++;
            rdy_cyc  = cyc;
            cap_next = 1'b1;
        end
        if (frm_err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (cap_next_d) begin
            pwr_after_d = pwr_up_d;
            cap_next_d  = 1'b0;
        end
        if (rx_rdy_d) begin
            rdy_n_d++;
            rdy_cyc_d  = cyc;
            pwr_at_d   = pwr_up_d;
            cap_next_d = 1'b1;
        end
        if (frm_err_d) err_n_d++;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // send one frame; t0 is the first clock edge that samples the start bit
    task automatic send(input bit sel, input logic [7:0] b, input bit stop_ok, output int t0);
        int         n;
        logic [9:0] fr;
        n  = sel ? ND : N;
        fr = {stop_ok, b, 1'b0};
        @(negedge clk);
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            if (sel) rx_d = fr[i];
            else     RX   = fr[i];
            repeat (n) @(negedge clk);
        end
        if (sel) rx_d = 1'b1;
        else     RX   = 1'b1;
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] b, input bit ro, input bit exp_pwr);
        int t0, r0;
        rider_off = ro;
        r0 = rdy_n;
        send(1'b0, b, 1'b1, t0);
        repeat (3) @(negedge clk);
        check({tag, " rdy_count"}, rdy_n - r0, 1);
        check({tag, " latency"}, rdy_cyc - t0, LAT);
        check({tag, " rx_data"}, rx_data, b);
        check({tag, " pwr_up"}, pwr_up, exp_pwr);
    endtask

    // reference model: powered flag plus "stop requested, waiting for rider to leave"
    bit m_on, m_wait_off;
    logic [7:0] m_last;

    task automatic m_rider(input bit ro);
        if (m_on && m_wait_off && ro) begin
            m_on       = 1'b0;
            m_wait_off = 1'b0;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ro);
        m_last = b;
        if (b == 8'h67) begin
            m_on       = 1'b1;
            m_wait_off = 1'b0;
        end else if (b == 8'h73 && m_on && !m_wait_off) begin
            if (ro) m_on = 1'b0;
            else    m_wait_off = 1'b1;
        end
        m_rider(ro);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         ro;
        bit         pwr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int t0, r0, e0;
        bit seen;

        tbl[0] = '{8'h73, 1'b0, 1'b0};
        tbl[1] = '{8'h12, 1'b0, 1'b0};
        tbl[2] = '{8'h67, 1'b1, 1'b1};
        tbl[3] = '{8'h67, 1'b0, 1'b1};
        tbl[4] = '{8'h55, 1'b1, 1'b1};
        tbl[5] = '{8'h73, 1'b0, 1'b1};
        tbl[6] = '{8'hAA, 1'b0, 1'b1};
        tbl[7] = '{8'h73, 1'b1, 1'b0};
        tbl[8] = '{8'h67, 1'b0, 1'b1};
        tbl[9] = '{8'h73, 1'b1, 1'b0};

        rst = 1'b1; RX = 1'b1; rx_d = 1'b1; rider_off = 1'b0; ro_d = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset rx_data", rx_data, 0);
        check("reset rx_rdy", rx_rdy, 0);
        check("reset frm_err", frm_err, 0);
        check("reset pwr_up", pwr_up, 0);
        check("reset pwr_up_def", pwr_up_d, 0);

        // default baud: exact latency and pwr_up one cycle after rx_rdy
        send(1'b1, 8'h67, 1'b1, t0);
        repeat (3) @(negedge clk);
        check("def rdy_count", rdy_n_d, 1);
        check("def latency", rdy_cyc_d - t0, LATD);
        check("def rx_data", rx_data_d, 8'h67);
        check("def pwr_at_rdy", pwr_at_d, 0);
        check("def pwr_after_rdy", pwr_after_d, 1);

        // 400-cycle glitch at default baud, then a 0x55 frame
        @(negedge clk);
        rx_d = 1'b0;
        repeat (400) @(negedge clk);
        rx_d = 1'b1;
        repeat (1400) @(negedge clk);
        check("glitch no_rdy", rdy_n_d, 1);
        check("glitch no_err", err_n_d, 0);
        send(1'b1, 8'h55, 1'b1, t0);
        repeat (3) @(negedge clk);
        check("post_glitch rdy_count", rdy_n_d, 2);
        check("post_glitch latency", rdy_cyc_d - t0, LATD);
        check("post_glitch rx_data", rx_data_d, 8'h55);
        check("post_glitch no_err", err_n_d, 0);

        // table of frames through the auth FSM
        for (int i = 0; i < 10; i++) begin
            frame_chk($sformatf("tbl%0d", i), tbl[i].b, tbl[i].ro, tbl[i].pwr);
        end

        // PWR2 then rider_off rises: pwr_up falls next cycle
        frame_chk("pwr2a", 8'h67, 1'b0, 1'b1);
        frame_chk("pwr2b", 8'h73, 1'b0, 1'b1);
        @(negedge clk);
        check("pwr2 before_rider_off", pwr_up, 1);
        rider_off = 1'b1;
        @(negedge clk);
        check("pwr2 after_rider_off", pwr_up, 0);

        // GO and rider_off in the same cycle while in PWR2
        frame_chk("simul_a", 8'h67, 1'b0, 1'b1);
        frame_chk("simul_b", 8'h73, 1'b0, 1'b1);
        seen = 1'b0;
        fork
            send(1'b0, 8'h67, 1'b1, t0);
            begin
                for (int k = 0; k < 2 * LAT; k++) begin
                    @(negedge clk);
                    if (!seen && rx_rdy) begin
                        rider_off = 1'b1;
                        seen      = 1'b1;
                    end
                end
            end
        join
        check("simul rdy_seen", seen, 1);
        check("simul pwr_after_rdy", pwr_after, 1);
        repeat (5) @(negedge clk);
        check("simul pwr_hold", pwr_up, 1);

        // framing error: counted, no rx_rdy, data kept, stays OFF
        frame_chk("ferr_a", 8'h73, 1'b0, 1'b1);
        rider_off = 1'b1;
        repeat (2) @(negedge clk);
        check("ferr pre_off", pwr_up, 0);
        r0 = rdy_n; e0 = err_n;
        send(1'b0, 8'h67, 1'b0, t0);
        repeat (3) @(negedge clk);
        check("ferr err_count", err_n - e0, 1);
        check("ferr latency", err_cyc - t0, LAT);
        check("ferr no_rdy", rdy_n - r0, 0);
        check("ferr rx_data", rx_data, 8'h73);
        check("ferr pwr_up", pwr_up, 0);

        // short glitch at test baud
        r0 = rdy_n; e0 = err_n;
        @(negedge clk);
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("short_glitch no_rdy", rdy_n - r0, 0);
        check("short_glitch no_err", err_n - e0, 0);

        // reset at data bit 4 of a 0x67 frame
        frame_chk("rst_a", 8'h67, 1'b0, 1'b1);
        r0 = rdy_n;
        @(negedge clk);
        RX = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = (8'h67 >> i) & 1;
            repeat (N) @(negedge clk);
        end
        RX = 1'b0;
        repeat (N / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst pwr_up", pwr_up, 0);
        check("midrst rx_data", rx_data, 0);
        rst = 1'b0;
        RX  = 1'b1;
        repeat (3 * N) @(negedge clk);
        check("midrst no_rdy", rdy_n - r0, 0);
        frame_chk("rst_b", 8'h67, 1'b0, 1'b1);

        // randomized frames against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_on = 1'b0; m_wait_off = 1'b0; m_last = 8'h00;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit ro, ok;
            case ($urandom_range(3))
                0:       b = 8'h67;
                1:       b = 8'h73;
                default: b = 8'($urandom_range(255));
            endcase
            ro = ($urandom_range(2) == 0);
            ok = ($urandom_range(7) != 0);
            rider_off = ro;
            m_rider(ro);
            r0 = rdy_n; e0 = err_n;
            send(1'b0, b, ok, t0);
            repeat (3) @(negedge clk);
            if (ok) m_byte(b, ro);
            check($sformatf("rnd%0d rdy", i), rdy_n - r0, int'(ok));
            check($sformatf("rnd%0d err", i), err_n - e0, int'(!ok));
            check($sformatf("rnd%0d rx_data", i), rx_data, m_last);
            check($sformatf("rnd%0d pwr_up", i), pwr_up, m_on);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
